// File: rtl/rsa_cmd_ctrl.sv
// Host command sequencer for the RSA wrapper: READ loads the operand, COMPUTE starts all cores and collects a result, WRITE returns it to BRAM.
// Each command is held until its handshake completes. Defining RSA_CMD_TIMEOUT_EN adds a compute watchdog of TIMEOUT_CYC cycles.
module rsa_cmd_ctrl #(
  parameter int DATA_W      = 1024,
  parameter int NUM_CORES   = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [31:0]                 port1_din,
  input  logic                        port1_valid,
  output logic                        port1_read,
  output logic                        port2_valid,
  input  logic                        port2_read,
  input  logic [DATA_W-1:0]           bram_din,
  input  logic                        bram_din_valid,
  output logic [DATA_W-1:0]           bram_dout,
  output logic                        bram_dout_valid,
  input  logic                        bram_dout_read,
  output logic [NUM_CORES-1:0]        core_start,
  input  logic [NUM_CORES-1:0]        core_done,
  output logic [DATA_W-1:0]           core_operand,
  input  logic [NUM_CORES*DATA_W-1:0] core_result,
  output logic [3:0]                  leds
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACK    = 3'd1,
    RD     = 3'd2,
    CSTART = 3'd3,
    CWAIT  = 3'd4,
    WR     = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t               state, state_nxt;
  logic [1:0]           opcode;
  logic [3:0]           idx;
  logic [DATA_W-1:0]    operand, result, result_sel;
  logic                 err;
  logic [NUM_CORES-1:0] done_seen;
  logic                 all_done, idx_ok, tmo_hit;
  logic                 cap_cmd, cap_operand, cap_result, set_err, clr_seen;

  // Done bits are sticky so cores finishing on different cycles are all collected.
  assign all_done = &(done_seen | core_done);
  assign idx_ok   = ({28'd0, idx} < 32'(NUM_CORES));

  always_comb begin
    result_sel = core_result[DATA_W-1:0];
    for (int i = 1; i < NUM_CORES; i++) begin
      if (idx == 4'(i)) result_sel = core_result[i*DATA_W +: DATA_W];
    end
  end

`ifdef RSA_CMD_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)              tmo_cnt <= '0;
    else if (state == CSTART) tmo_cnt <= '0;
    else if (state == CWAIT)  tmo_cnt <= tmo_cnt + 32'd1;
  end

  // The count lags the CWAIT entry by one cycle, so firing at TIMEOUT_CYC-1 gives exactly TIMEOUT_CYC cycles of waiting.
  assign tmo_hit = (tmo_cnt >= 32'(TIMEOUT_CYC - 1));
`else
  logic unused_tmo;
  assign unused_tmo = ^32'(TIMEOUT_CYC);
  assign tmo_hit    = 1'b0;
`endif

  logic unused_din;
  assign unused_din = ^{port1_din[31:8], port1_din[3:2]};

  always_comb begin
    state_nxt   = state;
    cap_cmd     = 1'b0;
    cap_operand = 1'b0;
    cap_result  = 1'b0;
    set_err     = 1'b0;
    clr_seen    = 1'b0;
    case (state)
      IDLE: if (port1_valid) begin
        cap_cmd   = 1'b1;
        state_nxt = ACK;
      end
      ACK: if (!port1_valid) begin
        case (opcode)
          2'd0:    state_nxt = RD;
          2'd1:    state_nxt = CSTART;
          2'd2:    state_nxt = WR;
          default: begin
            state_nxt = DONE;
            set_err   = 1'b1;
          end
        endcase
      end
      RD: if (bram_din_valid) begin
        cap_operand = 1'b1;
        state_nxt   = DONE;
      end
      CSTART: begin
        clr_seen  = 1'b1;
        state_nxt = CWAIT;
      end
      CWAIT: begin
        if (all_done) begin
          cap_result = 1'b1;
          set_err    = !idx_ok;
          state_nxt  = DONE;
        end else if (tmo_hit) begin
          set_err   = 1'b1;
          state_nxt = DONE;
        end
      end
      WR:   if (bram_dout_read) state_nxt = DONE;
      DONE: if (port2_read)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      opcode    <= '0;
      idx       <= '0;
      operand   <= '0;
      result    <= '0;
      err       <= 1'b0;
      done_seen <= '0;
    end else begin
      state <= state_nxt;
      if (cap_cmd) begin
        opcode <= port1_din[1:0];
        idx    <= port1_din[7:4];
        err    <= 1'b0;
      end
      if (set_err)     err     <= 1'b1;
      if (cap_operand) operand <= bram_din;
      if (cap_result)  result  <= result_sel;
      if (clr_seen)              done_seen <= '0;
      else if (state == CWAIT)   done_seen <= done_seen | core_done;
    end
  end

  assign port1_read      = (state == ACK);
  assign port2_valid     = (state == DONE);
  assign bram_dout_valid = (state == WR);
  assign bram_dout       = result;
  assign core_operand    = operand;
  assign core_start      = (state == CSTART) ? '1 : '0;
  assign leds            = {err, state};

endmodule
